// File: rtl/alu_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_queue_pkg
// Shared definitions for the ALU issue queue: station geometry, rename-tag
// width, datapath width, ALU op codes, the entry record, and the tag-wakeup
// helper. The dispatch-bypass path and the per-entry wakeup path both call
// that helper.
// -----------------------------------------------------------------------------
package alu_issue_queue_pkg;

  localparam int ENTRY_NUM    = 8;   // station entries (power of two)
  localparam int ENTRY_SEL    = 3;   // log2(ENTRY_NUM)
  localparam int RRF_SEL      = 6;   // rename-register tag width
  localparam int XPR_LEN      = 32;  // integer datapath width
  localparam int ALU_OP_WIDTH = 4;   // ALU op code width

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SLL  = 4'd1,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SRL  = 4'd5,
    ALU_OP_OR   = 4'd6,
    ALU_OP_AND  = 4'd7,
    ALU_OP_SEQ  = 4'd8,
    ALU_OP_SNE  = 4'd9,
    ALU_OP_SUB  = 4'd10,
    ALU_OP_SRA  = 4'd11,
    ALU_OP_SLT  = 4'd12,
    ALU_OP_SGE  = 4'd13,
    ALU_OP_SLTU = 4'd14,
    ALU_OP_SGEU = 4'd15
  } alu_op_e;

  // One source operand. When rdy is set, val is valid. Otherwise tag names
  // the producer to wait for.
  typedef struct packed {
    logic               rdy;
    logic [RRF_SEL-1:0] tag;
    logic [XPR_LEN-1:0] val;
  } operand_t;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    operand_t                src1;
    operand_t                src2;
    logic [RRF_SEL-1:0]      dst;
  } rs_entry_t;

  // Capture a writeback result into a waiting operand. wb0 is checked first,
  // so it wins if both buses carry the same tag. Operands that are already
  // ready pass through unchanged.
  function automatic operand_t wakeup(
    input operand_t           opnd,
    input logic               wb0_valid,
    input logic [RRF_SEL-1:0] wb0_tag,
    input logic [XPR_LEN-1:0] wb0_data,
    input logic               wb1_valid,
    input logic [RRF_SEL-1:0] wb1_tag,
    input logic [XPR_LEN-1:0] wb1_data
  );
    operand_t res;
    res = opnd;
    if (!opnd.rdy) begin
      if (wb0_valid && (wb0_tag == opnd.tag)) begin
        res.rdy = 1'b1;
        res.val = wb0_data;
      end else if (wb1_valid && (wb1_tag == opnd.tag)) begin
        res.rdy = 1'b1;
        res.val = wb1_data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// -----------------------------------------------------------------------------
// alu_issue_queue_if
// Bundle of the issue queue's non-clock signals.
//   flush                 : clear all entries (mispredict)
//   dp_*                  : dispatch request (op, operand values/ready/tags, dst)
//   full / count          : occupancy status
//   wb0_* / wb1_*         : two writeback buses (tag wakeup)
//   iss_*                 : registered issue port that drives the ALU
// Modport master is the surrounding pipeline. Modport slave is the queue.
// -----------------------------------------------------------------------------
interface alu_issue_queue_if;
  import alu_issue_queue_pkg::*;

  logic                    flush;

  logic                    dp_valid;
  logic [ALU_OP_WIDTH-1:0] dp_op;
  logic [XPR_LEN-1:0]      dp_src1;
  logic [XPR_LEN-1:0]      dp_src2;
  logic                    dp_rdy1;
  logic                    dp_rdy2;
  logic [RRF_SEL-1:0]      dp_tag1;
  logic [RRF_SEL-1:0]      dp_tag2;
  logic [RRF_SEL-1:0]      dp_dst;

  logic                    full;
  logic [ENTRY_SEL:0]      count;

  logic                    wb0_valid;
  logic [RRF_SEL-1:0]      wb0_tag;
  logic [XPR_LEN-1:0]      wb0_data;
  logic                    wb1_valid;
  logic [RRF_SEL-1:0]      wb1_tag;
  logic [XPR_LEN-1:0]      wb1_data;

  logic                    iss_valid;
  logic [ALU_OP_WIDTH-1:0] iss_op;
  logic [XPR_LEN-1:0]      iss_in1;
  logic [XPR_LEN-1:0]      iss_in2;
  logic [RRF_SEL-1:0]      iss_dst;

  modport master (
    output flush,
    output dp_valid, dp_op, dp_src1, dp_src2, dp_rdy1, dp_rdy2,
           dp_tag1, dp_tag2, dp_dst,
    output wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
    input  full, count,
    input  iss_valid, iss_op, iss_in1, iss_in2, iss_dst
  );

  modport slave (
    input  flush,
    input  dp_valid, dp_op, dp_src1, dp_src2, dp_rdy1, dp_rdy2,
           dp_tag1, dp_tag2, dp_dst,
    input  wb0_valid, wb0_tag, wb0_data, wb1_valid, wb1_tag, wb1_data,
    output full, count,
    output iss_valid, iss_op, iss_in1, iss_in2, iss_dst
  );

endinterface

// File: rtl/alu_issue_queue_prio_enc_lsb.sv
// -----------------------------------------------------------------------------
// prio_enc_lsb
// Lowest-set-bit priority encoder.
//   req   [WIDTH] : request vector
//   idx   [SEL]   : index of the lowest set bit (0 when none is set)
//   valid         : at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc_lsb #(
  parameter int WIDTH = 8,
  parameter int SEL   = 3
) (
  input  logic [WIDTH-1:0] req,
  output logic [SEL-1:0]   idx,
  output logic             valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = SEL'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
// ALU reservation station. It buffers renamed micro-ops until both source
// operands are ready, then issues one per cycle to the integer ALU.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : alu_issue_queue_if.slave (flush, dispatch, writeback, status, issue)
// Select uses the ready bits as registered at the start of the cycle, so an
// operand woken at edge N can issue at edge N+1 at the earliest. The free slot
// is chosen from busy bits before issue, so a slot freed by this cycle's
// issue is not reused in the same cycle.
// -----------------------------------------------------------------------------
module alu_issue_queue
  import alu_issue_queue_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  alu_issue_queue_if.slave   bus
);

  logic [ENTRY_NUM-1:0] busy;
  rs_entry_t            ent [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] free_req;
  logic [ENTRY_NUM-1:0] cand;
  logic [ENTRY_SEL-1:0] free_idx;
  logic [ENTRY_SEL-1:0] iss_idx;
  logic                 free_ok;
  logic                 iss_ok;
  logic                 dp_go;
  logic [ENTRY_SEL:0]   count_c;
  rs_entry_t            dp_entry;

  logic                    iss_valid_q;
  logic [ALU_OP_WIDTH-1:0] iss_op_q;
  logic [XPR_LEN-1:0]      iss_in1_q;
  logic [XPR_LEN-1:0]      iss_in2_q;
  logic [RRF_SEL-1:0]      iss_dst_q;

  assign free_req = ~busy;

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      cand[i] = busy[i] & ent[i].src1.rdy & ent[i].src2.rdy;
    end
  end

  prio_enc_lsb #(.WIDTH(ENTRY_NUM), .SEL(ENTRY_SEL)) u_free_sel (
    .req   (free_req),
    .idx   (free_idx),
    .valid (free_ok)
  );

  prio_enc_lsb #(.WIDTH(ENTRY_NUM), .SEL(ENTRY_SEL)) u_ready_sel (
    .req   (cand),
    .idx   (iss_idx),
    .valid (iss_ok)
  );

  // No free slot means every entry is busy.
  assign bus.full = ~free_ok;
  assign dp_go    = bus.dp_valid & free_ok;

  always_comb begin
    count_c = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      count_c = count_c + (ENTRY_SEL+1)'(busy[i]);
    end
  end
  assign bus.count = count_c;

  // Incoming op, with any operand that a writeback bus completes in the
  // dispatch cycle already captured (dispatch bypass).
  always_comb begin
    dp_entry.op   = bus.dp_op;
    dp_entry.dst  = bus.dp_dst;
    dp_entry.src1 = wakeup('{rdy: bus.dp_rdy1, tag: bus.dp_tag1, val: bus.dp_src1},
                           bus.wb0_valid, bus.wb0_tag, bus.wb0_data,
                           bus.wb1_valid, bus.wb1_tag, bus.wb1_data);
    dp_entry.src2 = wakeup('{rdy: bus.dp_rdy2, tag: bus.dp_tag2, val: bus.dp_src2},
                           bus.wb0_valid, bus.wb0_tag, bus.wb0_data,
                           bus.wb1_valid, bus.wb1_tag, bus.wb1_data);
  end

  // Control state: busy bits and the registered issue port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the block is ordered.
    if (reset) begin
      busy        <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_in1_q   <= '0;
      iss_in2_q   <= '0;
      iss_dst_q   <= '0;
    end else if (bus.flush) begin
      busy        <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      iss_valid_q <= iss_ok;
      if (iss_ok) begin
        busy[iss_idx] <= 1'b0;
        iss_op_q      <= ent[iss_idx].op;
        iss_in1_q     <= ent[iss_idx].src1.val;
        iss_in2_q     <= ent[iss_idx].src2.val;
        iss_dst_q     <= ent[iss_idx].dst;
      end
      // The free slot is never the issuing slot, so these writes never collide.
      if (dp_go) begin
        busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload storage.
  // NOTE: the payload array has no reset. The busy bits alone define which
  // entries are meaningful, and leaving storage unreset keeps it plain flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (dp_go && (free_idx == ENTRY_SEL'(i))) begin
        ent[i] <= dp_entry;
      end else if (busy[i]) begin
        ent[i].src1 <= wakeup(ent[i].src1,
                              bus.wb0_valid, bus.wb0_tag, bus.wb0_data,
                              bus.wb1_valid, bus.wb1_tag, bus.wb1_data);
        ent[i].src2 <= wakeup(ent[i].src2,
                              bus.wb0_valid, bus.wb0_tag, bus.wb0_data,
                              bus.wb1_valid, bus.wb1_tag, bus.wb1_data);
      end
    end
  end

  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_in1   = iss_in1_q;
  assign bus.iss_in2   = iss_in2_q;
  assign bus.iss_dst   = iss_dst_q;

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Reservation station that buffers renamed ALU micro-ops and supplies the integer ALU's op/in1/in2 inputs. It sits between dispatch and the ALU.
- Holds ops until both source operands are available.
- Captures operand values from two writeback buses (tag wakeup).
- Selects one ready entry per cycle and presents it on a registered issue port that drives the ALU directly.

Parameters:
ENTRY_NUM, 8, number of station entries (power of two)
ENTRY_SEL, 3, log2(ENTRY_NUM)
RRF_SEL, 6, width of rename-register (RRF) tag
XPR_LEN, 32, data width (matches rv32 header)
ALU_OP_WIDTH, 4, ALU op code width (matches ALU op header)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  sync clear of all entries (mispredict)
dp_valid  in  1  dispatch request
dp_op  in  ALU_OP_WIDTH  ALU op
dp_src1 / dp_src2  in  XPR_LEN  operand value, meaningful when ready
dp_rdy1 / dp_rdy2  in  1  operand value already valid
dp_tag1 / dp_tag2  in  RRF_SEL  producer tag when not ready
dp_dst  in  RRF_SEL  destination RRF tag
full  out  1  all entries busy
count  out  ENTRY_SEL+1  busy entry count
wb0_valid, wb1_valid  in  1  writeback bus valid
wb0_tag, wb1_tag  in  RRF_SEL  writeback tag
wb0_data, wb1_data  in  XPR_LEN  writeback value
iss_valid  out  1  issued op valid this cycle
iss_op  out  ALU_OP_WIDTH  to ALU op
iss_in1, iss_in2  out  XPR_LEN  to ALU in1/in2
iss_dst  out  RRF_SEL  destination tag

Behaviour:
- Reset (sync, highest priority): all busy bits 0; iss_valid, iss_op, iss_in1, iss_in2, iss_dst = 0; full=0; count=0.
- Flush (priority below reset, above all else): all busy bits cleared and iss_valid=0 at the same edge. A dp_valid in the flush cycle is dropped.
- full and count are combinational from the busy bits.
- Dispatch:
  - When dp_valid && !full, the op is written into the lowest-index free entry at the edge.
  - dp_valid while full is ignored (dispatcher protocol violation; no state change).
  - Dispatch bypass: if an operand is not ready and its tag matches a wbX_valid bus in the same cycle, it is stored ready with that bus's data.
- Wakeup: each busy, not-ready operand compares its tag against both buses each cycle. On a match it captures the data and sets ready at the edge. If both buses match the same tag, wb0 wins (duplicates are illegal upstream).
- Select:
  - Candidates are entries with busy && rdy1 && rdy2 as registered at the start of the cycle.
  - The lowest-index candidate wins. At the edge it is freed, and iss_* are loaded from it with iss_valid=1.
  - No candidate: iss_valid=0 and the other iss_* outputs hold their previous values.
- Latency:
  - A ready-at-dispatch op dispatched at edge N issues at edge N+1 (iss_valid visible in the cycle after N+1).
  - An operand woken at edge N makes its entry eligible for the select that completes at edge N+1. There is no same-cycle wakeup-to-issue.
- Simultaneous dispatch and issue in one cycle is allowed:
  - The freed slot is not reused in that cycle; the free slot is chosen from busy bits before issue.
  - count changes by +1, -1 or 0 accordingly.
- The ALU is combinational and always accepts, so there is no issue backpressure.
- Width rules: count saturates naturally at ENTRY_NUM (4'd8). Tags are compared on the full RRF_SEL width.

Decomposition:
- Shared header (alongside the ALU op and rv32 headers): ENTRY_NUM, ENTRY_SEL, RRF_SEL defines.
- Reuse ALU_OP_WIDTH and XPR_LEN from the existing headers.
- One natural sub-module: prio_enc_lsb. It is a parameterized lowest-set-bit priority encoder with valid output, instantiated twice: free-slot select and ready select.

Test Plan:
- Reset, then dispatch ADD (src1=5, src2=7, both ready, dst=3) -> one cycle later iss_valid=1, iss_op=ADD, iss_in1=5, iss_in2=7, iss_dst=3; count returns to 0.
- Dispatch SUB with tag1=12 not ready; two cycles later pulse wb1 tag=12 data=0x100 -> iss_valid exactly one cycle after the wb edge, iss_in1=0x100.
- Dispatch with dp_tag2=9 not ready and wb0 tag=9 data=0xAB in the same cycle -> issues next cycle with iss_in2=0xAB (dispatch bypass).
- Fill 8 never-ready entries -> full=1, count=8; extra dp_valid is ignored. Wake entry 5 -> it issues, full drops, next dispatch lands in slot 5.
- Entries 2 and 6 become ready at the same edge -> entry 2 issues first, entry 6 on the following cycle.
- Three busy entries plus dp_valid asserted together with flush -> next cycle count=0, iss_valid=0; a later wb matching the old tags causes no issue.
